// File: rtl/fpgc_pkg.sv
// fpgc_pkg: shared VRAM geometry and arbiter state encoding for the FPGC4 top level
package fpgc_pkg;
   localparam int VRAM_ADDR_W = 14;
   localparam int VRAM_DATA_W = 32;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_t;
endpackage

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port VRAM between FSX pixel fetch (priority) and one latched CPU access
module vram_arbiter
   import fpgc_pkg::*;
#(
   parameter int ADDR_W       = VRAM_ADDR_W,
   parameter int DATA_W       = VRAM_DATA_W,
   parameter int STARVE_LIMIT = 64
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              fsx_req,
   input  logic [ADDR_W-1:0] fsx_addr,
   output logic              fsx_stall,
   output logic              fsx_valid,
   output logic [DATA_W-1:0] fsx_q,
   input  logic              cpu_start,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_data,
   output logic              cpu_busy,
   output logic              cpu_done,
   output logic [DATA_W-1:0] cpu_q,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [DATA_W-1:0] vram_d,
   output logic              vram_we,
   input  logic [DATA_W-1:0] vram_q
);
   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
   arb_state_t        r_state;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic              r_done;
   logic              r_fsx_valid;
   logic [DATA_W-1:0] r_cpu_q;
   logic              w_starve;
   logic              w_cpu_slot;
   assign w_starve   = (STARVE_LIMIT != 0) && (r_wait_cnt == LIMIT);
   assign w_cpu_slot = (r_state == WAIT) && (!fsx_req || w_starve);
   assign vram_addr  = w_cpu_slot ? r_addr : fsx_addr;
   assign vram_d     = r_data;
   assign vram_we    = w_cpu_slot && r_we && !reset;
   assign fsx_stall  = fsx_req && w_cpu_slot;
   assign fsx_valid  = r_fsx_valid;
   assign fsx_q      = vram_q;
   assign cpu_busy   = (r_state != IDLE);
   assign cpu_done   = r_done;
   assign cpu_q      = r_cpu_q;
   // CPU access sequencing, starvation counting and registered handshake outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_data      <= '0;
         r_wait_cnt  <= '0;
         r_done      <= 1'b0;
         r_fsx_valid <= 1'b0;
         r_cpu_q     <= '0;
      end else begin
         r_fsx_valid <= fsx_req && !w_cpu_slot;
         r_done      <= (r_state == RESP);
         case (r_state)
            IDLE: if (cpu_start) begin
               r_we    <= cpu_we;
               r_addr  <= cpu_addr;
               r_data  <= cpu_data;
               r_state <= WAIT;
            end
            WAIT: if (w_cpu_slot) begin
               r_wait_cnt <= '0;
               r_state    <= RESP;
            end else if (fsx_req && r_wait_cnt != LIMIT) begin
               r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            RESP: begin
               if (!r_we) r_cpu_q <= vram_q;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and randomized checks of vram_arbiter against a transaction-level schedule model
module tb_vram_arbiter;
   localparam int AW = 14;
   localparam int DW = 32;
   localparam int N  = 4;
   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          fsx_req = 1'b0;
   logic [AW-1:0] fsx_addr = '0;
   logic          fsx_stall, fsx_valid;
   logic [DW-1:0] fsx_q;
   logic          cpu_start = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_data = '0;
   logic          cpu_busy, cpu_done;
   logic [DW-1:0] cpu_q;
   logic [AW-1:0] vram_addr;
   logic [DW-1:0] vram_d;
   logic          vram_we;
   logic [DW-1:0] vram_q = '0;

   vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(N)) dut (
      .clk(clk), .reset(reset),
      .fsx_req(fsx_req), .fsx_addr(fsx_addr), .fsx_stall(fsx_stall), .fsx_valid(fsx_valid), .fsx_q(fsx_q),
      .cpu_start(cpu_start), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_q(cpu_q),
      .vram_addr(vram_addr), .vram_d(vram_d), .vram_we(vram_we), .vram_q(vram_q)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_word(input int i);
      return (DW'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   // synchronous-read VRAM: data appears one cycle after the address
   logic [DW-1:0] mem [0:(1<<AW)-1];
   initial for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
   always @(posedge clk) begin
      if (vram_we) mem[vram_addr] <= vram_d;
      vram_q <= mem[vram_addr];
   end

   // expected memory contents and transaction schedule
   logic [DW-1:0] shadow [0:(1<<AW)-1];
   int            compared = 0, mismatched = 0;
   int            cyc = 0, slot_cyc = -1, done_cyc = -1, busy_lo = 0, busy_hi = -1;
   logic          op_we = 1'b0, done_rd = 1'b0, last_grant = 1'b0;
   logic [AW-1:0] op_a = '0, last_fa = '0;
   logic [DW-1:0] op_d = '0, pend_q = '0, model_q = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic tick(input logic rst, input logic fr, input logic [AW-1:0] fa, input logic cs,
                       input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
      logic sl;
      @(negedge clk);
      reset = rst; fsx_req = fr; fsx_addr = fa;
      cpu_start = cs; cpu_we = cw; cpu_addr = ca; cpu_data = cd;
      #1;
      sl = (cyc == slot_cyc);
      if (cyc == done_cyc && done_rd) model_q = pend_q;
      chk("cpu_busy", cpu_busy, cyc >= busy_lo && cyc <= busy_hi);
      chk("cpu_done", cpu_done, cyc == done_cyc);
      chk("cpu_q", cpu_q, model_q);
      chk("fsx_valid", fsx_valid, last_grant);
      if (last_grant) chk("fsx_q", fsx_q, shadow[last_fa]);
      chk("fsx_stall", fsx_stall, fr && sl);
      chk("vram_we", vram_we, sl && op_we && !rst);
      chk("vram_addr", vram_addr, sl ? op_a : fa);
      if (sl) chk("vram_d", vram_d, op_d);
      last_grant = fr && !sl && !rst;
      last_fa = fa;
      if (sl && op_we && !rst) shadow[op_a] = op_d;
      if (sl && !op_we) pend_q = shadow[op_a];
      if (rst) begin
         slot_cyc = -1; done_cyc = -1; busy_lo = 0; busy_hi = -1; model_q = '0;
      end
      cyc++;
   endtask

   // record an op accepted in the previous tick; slot is its grant offset from the start cycle
   task automatic accept(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int slot);
      int c0;
      c0 = cyc - 1;
      op_we = we; op_a = a; op_d = d; done_rd = !we;
      slot_cyc = c0 + slot; busy_lo = c0 + 1; busy_hi = c0 + slot + 1; done_cyc = c0 + slot + 2;
   endtask

   // mode: 0 no FSX, 1 FSX always, 2 FSX toggling, 3 random FSX; ign_k>0 issues an ignored start at that offset
   task automatic run_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int mode, input int ign_k, input bit b2b);
      logic req [0:8];
      int   slot, last;
      for (int k = 0; k <= 8; k++)
         req[k] = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : (mode == 2) ? (k % 2 == 1) : ($urandom_range(0, 3) != 0);
      slot = N + 1;
      for (int k = N; k >= 1; k--) if (!req[k]) slot = k;
      last = b2b ? slot + 1 : slot + 3;
      for (int k = 0; k <= last; k++) begin
         if (k == 0)
            tick(1'b0, req[k], AW'($urandom_range(0, 31)), 1'b1, we, a, d);
         else
            tick(1'b0, req[k], AW'($urandom_range(0, 31)), k == ign_k, (k == ign_k) ? 1'b1 : 1'($urandom),
                 a ^ AW'(32), $urandom);
         if (k == 0) accept(we, a, d, slot);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++)
         tick(1'b0, 1'($urandom), AW'($urandom_range(0, 31)), 1'b0, 1'($urandom), AW'($urandom), $urandom);
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) shadow[i] = init_word(i);
      repeat (2) @(posedge clk);
      tick(1'b1, 1'b0, 14'h0001, 1'b0, 1'b0, '0, '0);
      tick(1'b1, 1'b1, 14'h0002, 1'b0, 1'b0, '0, '0);
      tick(1'b0, 1'b0, 14'h0003, 1'b0, 1'b0, '0, '0);
      // write then read back with FSX idle
      run_op(1'b1, 14'h0010, 32'hDEAD_BEEF, 0, 0, 1'b0);
      run_op(1'b0, 14'h0010, 32'h0, 0, 0, 1'b0);
      chk("readback_q", cpu_q, 32'hDEAD_BEEF);
      // continuous FSX traffic forces a starvation slot
      run_op(1'b0, 14'h0010, 32'h0, 1, 0, 1'b0);
      run_op(1'b1, 14'h0011, 32'h1234_5678, 1, 0, 1'b0);
      // toggling FSX: CPU takes the first free cycle
      run_op(1'b0, 14'h0011, 32'h0, 2, 0, 1'b0);
      // starts while busy are ignored
      run_op(1'b1, 14'h0003, 32'hCAFE_F00D, 1, 2, 1'b0);
      run_op(1'b0, 14'h0023, 32'h0, 0, 1, 1'b0);
      run_op(1'b0, 14'h0003, 32'h0, 0, 0, 1'b0);
      // back-to-back: next start on the done cycle
      run_op(1'b1, 14'h0004, 32'hA5A5_0004, 0, 0, 1'b1);
      run_op(1'b0, 14'h0004, 32'h0, 0, 0, 1'b1);
      run_op(1'b0, 14'h0010, 32'h0, 1, 0, 1'b0);
      // reset coinciding with the write slot drops the write
      tick(1'b0, 1'b0, 14'h0001, 1'b1, 1'b1, 14'h0007, 32'h7777_7777);
      accept(1'b1, 14'h0007, 32'h7777_7777, 1);
      tick(1'b1, 1'b0, 14'h0002, 1'b0, 1'b0, '0, '0);
      tick(1'b0, 1'b0, 14'h0003, 1'b0, 1'b0, '0, '0);
      idle(2);
      run_op(1'b0, 14'h0007, 32'h0, 0, 0, 1'b0);
      // reset during a blocked WAIT drops the pending write
      tick(1'b0, 1'b0, 14'h0001, 1'b1, 1'b1, 14'h0008, 32'h8888_8888);
      accept(1'b1, 14'h0008, 32'h8888_8888, 1000);
      tick(1'b0, 1'b1, 14'h0002, 1'b0, 1'b0, '0, '0);
      tick(1'b1, 1'b1, 14'h0003, 1'b0, 1'b0, '0, '0);
      tick(1'b0, 1'b0, 14'h0004, 1'b0, 1'b0, '0, '0);
      idle(2);
      run_op(1'b0, 14'h0008, 32'h0, 0, 0, 1'b0);
      // randomized traffic
      for (int t = 0; t < 40; t++) begin
         run_op(1'($urandom), AW'($urandom_range(0, 31)), $urandom, $urandom_range(0, 3),
                $urandom_range(0, 1), 1'($urandom));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      idle(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
